// File: rtl/fetch_pc_seq_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pc_seq_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned OFFSET_W    = 16;
    localparam int unsigned JIDX_W      = 26;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        INC   = 2'd2,
        BR    = 2'd3
    } state_t;

    // Control-flow decision captured from the decoder when it accepts an instruction.
    typedef struct packed {
        logic                br_take;
        logic [OFFSET_W-1:0] br_offset;
        logic                jmp;
        logic [JIDX_W-1:0]   jmp_index;
    } flow_t;

    // Sign-extended word offset converted to a byte displacement.
    function automatic logic [XLEN-1:0] br_disp(input logic [OFFSET_W-1:0] off);
        return {{(XLEN-OFFSET_W-2){off[OFFSET_W-1]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_seq_if.sv
// Fetch/issue bus between the sequencer, instruction memory and the decoder.
interface fetch_pc_seq_if;
    import fetch_pc_seq_pkg::*;

    logic                imem_req;
    logic [XLEN-1:0]     imem_addr;
    logic                imem_ack;
    logic [XLEN-1:0]     imem_rdata;
    logic                instr_valid;
    logic                instr_ready;
    logic [XLEN-1:0]     instr_out;
    logic [XLEN-1:0]     instr_pc;
    logic                br_take;
    logic [OFFSET_W-1:0] br_offset;
    logic                jmp;
    logic [JIDX_W-1:0]   jmp_index;
    logic                redirect;
    logic [XLEN-1:0]     redirect_pc;
    logic                pc_wrap;

    modport master (
        output imem_req, imem_addr, instr_valid, instr_out, instr_pc, pc_wrap,
        input  imem_ack, imem_rdata, instr_ready, br_take, br_offset, jmp, jmp_index,
               redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr_out, instr_pc, pc_wrap,
        output imem_ack, imem_rdata, instr_ready, br_take, br_offset, jmp, jmp_index,
               redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_pc_seq_adder.sv
// Combinational 32-bit adder shared by PC increment and branch-target computation.
module pc_adder32
    import fetch_pc_seq_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] s,
    output logic            carry,
    output logic            ovf,
    output logic            zero
);

    always_comb begin
        {carry, s} = (XLEN+1)'(a) + (XLEN+1)'(b);
        ovf        = (a[XLEN-1] == b[XLEN-1]) && (s[XLEN-1] != a[XLEN-1]);
        zero       = (s == '0);
    end

endmodule

// File: rtl/fetch_pc_seq.sv
// Instruction-fetch sequencer: owns the PC, runs the imem handshake and issues
// instructions to decode, sharing one adder between PC+4 and branch targets.
module fetch_pc_seq
    import fetch_pc_seq_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           clk,
    input  logic           rst_n,
    fetch_pc_seq_if.master bus
);

    state_t          state, state_nx;
    logic [XLEN-1:0] pc, pc_nx;
    logic [XLEN-1:0] pend_pc, pend_pc_nx;
    logic [XLEN-1:0] instr_out, instr_out_nx;
    logic [XLEN-1:0] instr_pc, instr_pc_nx;
    logic            pend, pend_nx;
    logic            req, req_nx;
    logic            valid, valid_nx;
    logic            wrap, wrap_nx;
    flow_t           flow, flow_nx;

    logic [XLEN-1:0] add_b, add_s;
    logic            add_ovf, unused_carry, unused_zero;

    // Operand B is the branch displacement in BR, otherwise one instruction.
    assign add_b = (state == BR) ? br_disp(flow.br_offset) : XLEN'(INSTR_BYTES);

    pc_adder32 u_adder (
        .a     (pc),
        .b     (add_b),
        .s     (add_s),
        .carry (unused_carry),
        .ovf   (add_ovf),
        .zero  (unused_zero)
    );

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        pend_nx      = pend;
        pend_pc_nx   = pend_pc;
        flow_nx      = flow;
        req_nx       = req;
        valid_nx     = valid;
        instr_out_nx = instr_out;
        instr_pc_nx  = instr_pc;
        wrap_nx      = 1'b0;

        // Outside FETCH a redirect aborts whatever is in flight.
        if (state != FETCH && bus.redirect) begin
            pc_nx    = bus.redirect_pc;
            valid_nx = 1'b0;
            req_nx   = 1'b1;
            state_nx = FETCH;
        end else begin
            case (state)
                FETCH: begin
                    if (!req) begin
                        req_nx = 1'b1;
                        if (bus.redirect) pc_nx = bus.redirect_pc;
                    end else if (bus.imem_ack) begin
                        req_nx  = 1'b0;
                        pend_nx = 1'b0;
                        if (bus.redirect) begin
                            pc_nx = bus.redirect_pc;
                        end else if (pend) begin
                            pc_nx = pend_pc;
                        end else begin
                            instr_out_nx = bus.imem_rdata;
                            instr_pc_nx  = pc;
                            valid_nx     = 1'b1;
                            state_nx     = ISSUE;
                        end
                    end else if (bus.redirect) begin
                        // Request already on the bus: remember target until ack.
                        pend_nx    = 1'b1;
                        pend_pc_nx = bus.redirect_pc;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        flow_nx  = '{br_take:   bus.br_take,
                                     br_offset: bus.br_offset,
                                     jmp:       bus.jmp,
                                     jmp_index: bus.jmp_index};
                        valid_nx = 1'b0;
                        state_nx = INC;
                    end
                end
                INC: begin
                    pc_nx = add_s;
                    if (flow.jmp) begin
                        pc_nx    = {add_s[XLEN-1:XLEN-4], flow.jmp_index, 2'b00};
                        req_nx   = 1'b1;
                        state_nx = FETCH;
                    end else if (flow.br_take) begin
                        state_nx = BR;
                    end else begin
                        req_nx   = 1'b1;
                        state_nx = FETCH;
                    end
                end
                BR: begin
                    pc_nx    = add_s;
                    wrap_nx  = add_ovf;
                    req_nx   = 1'b1;
                    state_nx = FETCH;
                end
                default: state_nx = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            pend      <= 1'b0;
            pend_pc   <= '0;
            flow      <= '0;
            req       <= 1'b0;
            valid     <= 1'b0;
            instr_out <= '0;
            instr_pc  <= '0;
            wrap      <= 1'b0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            pend      <= pend_nx;
            pend_pc   <= pend_pc_nx;
            flow      <= flow_nx;
            req       <= req_nx;
            valid     <= valid_nx;
            instr_out <= instr_out_nx;
            instr_pc  <= instr_pc_nx;
            wrap      <= wrap_nx;
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.instr_valid = valid;
    assign bus.instr_out   = instr_out;
    assign bus.instr_pc    = instr_pc;
    assign bus.pc_wrap     = wrap;

endmodule

// File: tb/tb_fetch_pc_seq.sv
// Self-checking bench for fetch_pc_seq: directed scenarios then randomized
// fetch/issue traffic against a transaction-level next-PC model.
module tb_fetch_pc_seq;
    import fetch_pc_seq_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    fetch_pc_seq_if bus();

    fetch_pc_seq #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Wait (bounded) for the sequencer to raise imem_req; returns the cycle it was seen.
    task automatic wait_req(output int at);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            chk("no_valid_while_fetching", 32'(bus.instr_valid), 32'd0);
            step();
            n++;
        end
        if (bus.imem_req !== 1'b1) chk("req_timeout", 32'(bus.imem_req), 32'd1);
        at = cyc;
    endtask

    // Serve one fetch; optionally raise a one-cycle redirect at cycle rd_at of the wait.
    task automatic fetch(input logic [31:0] exp_addr, input int delay, input logic [31:0] rdata,
                         input bit do_rd, input int rd_at, input logic [31:0] rd_pc);
        for (int i = 0; i <= delay; i++) begin
            chk("imem_req_held", 32'(bus.imem_req), 32'd1);
            chk("imem_addr", bus.imem_addr, exp_addr);
            bus.imem_ack    = (i == delay);
            bus.imem_rdata  = (i == delay) ? rdata : 32'hDEAD_BEEF;
            bus.redirect    = do_rd && (i == rd_at);
            bus.redirect_pc = rd_pc;
            step();
        end
        bus.imem_ack = 1'b0;
        bus.redirect = 1'b0;
        if (do_rd) begin
            chk("discard_valid", 32'(bus.instr_valid), 32'd0);
            chk("discard_req", 32'(bus.imem_req), 32'd0);
        end else begin
            chk("instr_valid", 32'(bus.instr_valid), 32'd1);
            chk("instr_pc", bus.instr_pc, exp_addr);
            chk("instr_out", bus.instr_out, rdata);
        end
    endtask

    // Hold ready low for 'stall' cycles, then accept (or redirect in the accepting cycle).
    task automatic issue(input int stall, input logic [31:0] exp_pc, input logic [31:0] exp_ins,
                         input bit br, input logic [15:0] off, input bit jp, input logic [25:0] idx,
                         input bit rd, input logic [31:0] rd_pc, output int acc);
        for (int i = 0; i < stall; i++) begin
            bus.instr_ready = 1'b0;
            step();
            chk("stall_valid", 32'(bus.instr_valid), 32'd1);
            chk("stall_pc", bus.instr_pc, exp_pc);
            chk("stall_out", bus.instr_out, exp_ins);
            chk("stall_req", 32'(bus.imem_req), 32'd0);
        end
        bus.instr_ready = 1'b1;
        bus.br_take     = br;
        bus.br_offset   = off;
        bus.jmp         = jp;
        bus.jmp_index   = idx;
        bus.redirect    = rd;
        bus.redirect_pc = rd_pc;
        acc = cyc;
        step();
        bus.instr_ready = 1'b0;
        bus.br_take     = 1'b0;
        bus.jmp         = 1'b0;
        bus.redirect    = 1'b0;
        chk("valid_drop", 32'(bus.instr_valid), 32'd0);
    endtask

    initial begin
        int          t_req, t_acc, t_new, exp_lat, delay, stall, rd_at;
        logic [31:0] exp_pc, seq, rdata, rd_pc;
        logic [15:0] off;
        logic [25:0] idx;
        bit          exp_wrap, f_rd, i_rd, br, jp;
        longint      tgt;

        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus.instr_ready = 1'b0;
        bus.br_take     = 1'b0;
        bus.br_offset   = '0;
        bus.jmp         = 1'b0;
        bus.jmp_index   = '0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Reset values
        #2 rst_n = 1'b0;
        #10;
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_out", bus.instr_out, 32'h0);
        chk("rst_pc", bus.instr_pc, 32'h0);
        chk("rst_wrap", 32'(bus.pc_wrap), 32'd0);
        rst_n = 1'b1;
        step();
        chk("first_req", 32'(bus.imem_req), 32'd1);

        // Sequential fetch 0x0, 0x4, 0x8 with immediate ack and ready
        wait_req(t_req);
        for (int k = 0; k < 3; k++) begin
            fetch(32'(4 * k), 0, 32'h1000 + 32'(k), 1'b0, 0, '0);
            issue(0, 32'(4 * k), 32'h1000 + 32'(k), 1'b0, '0, 1'b0, '0, 1'b0, '0, t_acc);
            wait_req(t_new);
            chk("seq_latency", 32'(t_new - t_acc), 32'd2);
            chk("seq_period", 32'(t_new - t_req), 32'd3);
            t_req = t_new;
        end

        // Redirect coincident with ack: go to 0x100, then taken branch back by 4 words
        fetch(32'hC, 0, 32'h1, 1'b1, 0, 32'h100);
        wait_req(t_req);
        fetch(32'h100, 0, 32'h2, 1'b0, 0, '0);
        issue(0, 32'h100, 32'h2, 1'b1, 16'hFFFC, 1'b0, '0, 1'b0, '0, t_acc);
        wait_req(t_new);
        chk("br_latency", 32'(t_new - t_acc), 32'd3);
        chk("br_nowrap", 32'(bus.pc_wrap), 32'd0);

        // Redirect in the accepting cycle wins; then jump (with br_take) to 0x3000_0100
        fetch(32'h0F4, 0, 32'h3, 1'b0, 0, '0);
        issue(0, 32'h0F4, 32'h3, 1'b1, 16'h0010, 1'b0, '0, 1'b1, 32'h3000_0010, t_acc);
        wait_req(t_new);
        chk("redirect_latency", 32'(t_new - t_acc), 32'd1);
        fetch(32'h3000_0010, 0, 32'h4, 1'b0, 0, '0);
        issue(0, 32'h3000_0010, 32'h4, 1'b1, 16'h0100, 1'b1, 26'h40, 1'b0, '0, t_acc);
        wait_req(t_new);
        chk("jmp_latency", 32'(t_new - t_acc), 32'd2);

        // Redirect while waiting 3 cycles for ack: address held, data discarded
        fetch(32'h3000_0100, 3, 32'h5, 1'b1, 1, 32'h80);
        wait_req(t_new);
        fetch(32'h80, 1, 32'h6, 1'b0, 0, '0);

        // Decoder stall then reset mid-ISSUE
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_out", bus.instr_out, 32'h6);
            chk("hold_pc", bus.instr_pc, 32'h80);
            chk("hold_req", 32'(bus.imem_req), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.instr_valid), 32'd0);
        chk("async_addr", bus.imem_addr, 32'h0);
        #2 rst_n = 1'b1;
        step();
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", bus.imem_addr, 32'h0);

        // Branch-target signed overflow
        fetch(32'h0, 0, 32'h7, 1'b0, 0, '0);
        issue(0, 32'h0, 32'h7, 1'b0, '0, 1'b0, '0, 1'b1, 32'h7FFF_FFF0, t_acc);
        wait_req(t_new);
        fetch(32'h7FFF_FFF0, 0, 32'h8, 1'b0, 0, '0);
        issue(0, 32'h7FFF_FFF0, 32'h8, 1'b1, 16'h0004, 1'b0, '0, 1'b0, '0, t_acc);
        step();
        chk("wrap_inc", 32'(bus.pc_wrap), 32'd0);
        step();
        chk("wrap_req", 32'(bus.imem_req), 32'd1);
        chk("wrap_addr", bus.imem_addr, 32'h8000_0004);
        chk("wrap_pulse", 32'(bus.pc_wrap), 32'd1);
        step();
        chk("wrap_clear", 32'(bus.pc_wrap), 32'd0);

        // Randomized traffic against the next-PC model
        exp_pc   = 32'h8000_0004;
        exp_lat  = 0;
        exp_wrap = 1'b0;
        t_acc    = 0;
        for (int n = 0; n < 150; n++) begin
            wait_req(t_new);
            if (exp_lat != 0) chk("rnd_latency", 32'(t_new - t_acc), 32'(exp_lat));
            chk("rnd_wrap", 32'(bus.pc_wrap), 32'(exp_wrap));
            exp_wrap = 1'b0;
            exp_lat  = 0;
            delay = int'($urandom_range(0, 3));
            rdata = $urandom();
            rd_pc = $urandom() & 32'hFFFF_FFFC;
            f_rd  = ($urandom_range(0, 9) == 0);
            rd_at = int'($urandom_range(0, 32'(delay)));
            fetch(exp_pc, delay, rdata, f_rd, rd_at, rd_pc);
            if (f_rd) begin
                exp_pc = rd_pc;
                continue;
            end
            stall = int'($urandom_range(0, 3));
            i_rd  = ($urandom_range(0, 9) == 0);
            jp    = ($urandom_range(0, 5) == 0);
            br    = ($urandom_range(0, 2) == 0);
            off   = 16'($urandom());
            idx   = 26'($urandom());
            issue(stall, exp_pc, rdata, br, off, jp, idx, i_rd, rd_pc, t_acc);
            seq = exp_pc + 32'd4;
            if (i_rd) begin
                exp_pc  = rd_pc;
                exp_lat = 1;
            end else if (jp) begin
                exp_pc  = {seq[31:28], idx, 2'b00};
                exp_lat = 2;
            end else if (br) begin
                tgt      = longint'($signed(seq)) + longint'($signed(off)) * 4;
                exp_pc   = tgt[31:0];
                exp_wrap = (tgt > 64'sd2147483647) || (tgt < -64'sd2147483648);
                exp_lat  = 3;
            end else begin
                exp_pc  = seq;
                exp_lat = 2;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_pc_seq.md
# fetch_pc_seq

Instruction-fetch sequencer for the single-cycle/multi-cycle datapath: owns the PC, drives the instruction-memory request handshake and time-shares one 32-bit adder between sequential increment (PC+4) and branch-target computation (PC+4+offset·4). Sits between instruction memory and the decode stage; the decoder consumes instructions through a valid/ready handshake and returns branch/jump/redirect decisions in the accepting cycle.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded at reset (word aligned)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch byte address
- imem_ack  in  1  fetch complete; imem_rdata valid this cycle
- imem_rdata  in  32  fetched instruction
- instr_valid  out  1  instr_out/instr_pc valid
- instr_ready  in  1  decoder accepts
- instr_out  out  32  held instruction
- instr_pc  out  32  address of instr_out
- br_take  in  1  conditional branch taken (sampled on accept)
- br_offset  in  16  signed word offset
- jmp  in  1  J-type jump (sampled on accept)
- jmp_index  in  26  jump word index
- redirect  in  1  external redirect (exception/restart), any cycle
- redirect_pc  in  32  redirect target
- pc_wrap  out  1  one-cycle pulse: signed overflow in branch-target add

Reset (rst_n low, immediate): pc=RESET_PC, state=FETCH, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0, pc_wrap=0, redirect pending flag=0.

## Operation
States: FETCH, ISSUE, INC, BR.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: if pending redirect, discard rdata, pc<=pending target, clear pending, stay FETCH (req drops one cycle); else instr_out<=imem_rdata, instr_pc<=pc, -> ISSUE.
- ISSUE: instr_valid=1, outputs held stable. On instr_valid&instr_ready: latch br_take/br_offset/jmp/jmp_index, -> INC.
- INC: adder A=pc, B=32'd4; pc<=sum (mod 2^32). If latched jmp: pc<={sum[31:28],jmp_index,2'b00}, -> FETCH. Else if br_take -> BR. Else -> FETCH.
- BR: adder A=pc (already PC+4), B=sext(br_offset)<<2; pc<=sum mod 2^32; pc_wrap pulses if adder signed overflow; -> FETCH.
- Priority if latched simultaneously: jmp > br_take.
- redirect: in ISSUE/INC/BR: pc<=redirect_pc, instr_valid drops next cycle, latched branch/jump discarded, -> FETCH. In FETCH with imem_req already high: request is never withdrawn; target stored as pending, applied at ack. Redirect in FETCH same cycle as ack: treated as pending (instruction discarded). Redirect in the ISSUE accepting cycle: redirect wins, no INC.
- Handshake rules: imem_req/imem_addr stable from assertion to ack; instr_out/instr_pc stable while instr_valid&!instr_ready.
- Adder is the only arithmetic on pc; no other incrementer.

## Timing
- Accept at cycle t (sequential): INC t+1, imem_req high t+2.
- Taken branch: INC t+1, BR t+2, imem_req t+3.
- Jump: imem_req t+2.
- imem_ack in first req cycle: instr_valid next cycle. Minimum instruction period 3 cycles (FETCH, ISSUE, INC).
- Redirect outside FETCH: imem_req with redirect_pc on next cycle.
- Reset mid-operation: all outputs to reset values asynchronously; first imem_req one cycle after rst_n deasserts.

## Structure
- Shared header/package: state encoding constants, INSTR_BYTES=4, default RESET_PC.
- One sub-module: pc_adder32 — combinational 32-bit adder (A, B → S, carry, signed overflow, zero), instantiated once, operand muxes in the sequencer.

## Test plan
- Reset release, imem_ack same cycle each fetch, instr_ready=1: addresses 0x0,0x4,0x8, one request every 3 cycles.
- At pc 0x100 accept br_take=1, br_offset=16'hFFFC: next imem_addr 0x0F4 at t+3.
- At pc 0x3000_0010 accept jmp=1, jmp_index=26'h40: next imem_addr 0x3000_0100 at t+2; jmp+br_take together → jump wins.
- redirect=1, redirect_pc=0x80 while FETCH waiting 3 cycles for ack: imem_addr stays old until ack, rdata discarded, next req at 0x80; instr_valid never raised for old address.
- instr_ready=0 for 5 cycles in ISSUE: instr_out/instr_pc stable, no imem_req; then rst_n low mid-ISSUE → instr_valid=0 immediately, restart at RESET_PC.
- pc 0x7FFF_FFF0, br_offset=16'h0004: target 0x8000_0004, pc_wrap one-cycle pulse.
